// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store access.
// Data has fixed priority; a burst counter guarantees fetch a slot, and a wait counter bounds each access.
module mem_port_arbiter #(
    parameter int AWIDTH         = 32,
    parameter int DWIDTH         = 32,
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [AWIDTH-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DWIDTH-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic [DWIDTH-1:0] d_wdata,
    input  logic [2:0]        d_size,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DWIDTH-1:0] d_rdata,
    output logic              err,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic [2:0]        mem_size,
    input  logic              mem_ready,
    input  logic [DWIDTH-1:0] mem_rdata
);

    // Handshake: a requester holds *_req until *_gnt is seen high in an IDLE
    // cycle; the access is taken at that clock edge and answered by exactly one
    // *_rvalid pulse (err set if memory never answered), or by nothing if reset.
    localparam int BW = $clog2(MAX_DATA_BURST + 1);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [BW-1:0]   burst_cnt;
    logic [WW-1:0]   wait_cnt;
    logic            grant_d;
    logic            grant_i;
    logic            done_ok;
    logic            done_to;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        done_ok    = 1'b0;
        done_to    = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    // Data wins unless fetch has already waited through a full burst.
                    if (d_req && !(if_req && burst_cnt == BURST_MAX)) begin
                        grant_d    = 1'b1;
                        state_next = DATA;
                    end else if (if_req) begin
                        grant_i    = 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            FETCH, DATA: begin
                if (mem_req) begin
                    if (mem_ready) begin
                        done_ok    = 1'b1;
                        state_next = IDLE;
                    end else if (wait_cnt == WAIT_MAX) begin
                        done_to    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign d_gnt  = grant_d;
    assign if_gnt = grant_i;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_size  <= 3'b000;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            err       <= 1'b0;
            burst_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            err       <= 1'b0;
            if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_size  <= d_size;
                wait_cnt  <= '0;
                if (!if_req) begin
                    burst_cnt <= '0;
                end else if (burst_cnt != BURST_MAX) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end else if (grant_i) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_size  <= 3'b010;
                wait_cnt  <= '0;
                burst_cnt <= '0;
            end
            if (done_ok || done_to) begin
                mem_req  <= 1'b0;
                wait_cnt <= '0;
                err      <= done_to;
                if (state == FETCH) begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= done_ok ? mem_rdata : '0;
                end else begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= (done_ok && !mem_we) ? mem_rdata : '0;
                end
            end else if (state != IDLE && mem_req && !mem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: requester drivers push expected responses,
// a negedge monitor checks grants, memory-side fields, response timing and data.
module tb_mem_port_arbiter;

    localparam int TIMEOUT_P = 16;
    localparam int MAXB      = 4;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_size;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        err;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_size;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(
        .AWIDTH(32), .DWIDTH(32), .MAX_DATA_BURST(MAXB), .TIMEOUT(TIMEOUT_P)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .err(err), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [32:0] if_exp_q[$];
    logic [32:0] d_exp_q[$];
    bit          gnt_log[$];
    int n_vec = 0;
    int n_mis = 0;

    // reference model state
    int          cyc = 0;
    bit          rst_prev = 0;
    bit          pend = 0;
    bit          pend_fetch = 0;
    bit          done_next = 0;
    int          ds = 0;
    int          stall_cnt = 0;
    int          run = 0;
    int          f_gnt_cyc = 0;
    int          d_rv_cyc = 0;
    int          f_rv_cyc = 0;
    logic        acc_we;
    logic [2:0]  acc_size;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;

    // memory environment
    bit stall = 0;
    int fix_lat = 0;
    int lat = 1;
    int acc_cyc = 0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_mis++;
        $display("FAIL %s: event did not occur, t=%0t", name, $time);
    endtask

    // ---------------- memory responder ----------------
    always begin
        @(posedge clk);
        #1;
        if (mem_req) begin
            acc_cyc++;
            if (!stall && acc_cyc == lat) begin
                mem_ready = 1'b1;
                mem_rdata = mem_val(mem_addr);
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
        end else begin
            acc_cyc   = 0;
            lat       = (fix_lat != 0) ? fix_lat : $urandom_range(1, 4);
            mem_ready = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end
    end

    // ---------------- monitor / reference model ----------------
    always @(negedge clk) begin
        bit rv;
        bit exp_d;
        bit exp_i;
        logic [32:0] e;
        cyc++;
        if (rst) begin
            check("gnt_in_reset", 96'({if_gnt, d_gnt}), 96'(0));
            if (rst_prev) begin
                check("reset_flags", 96'({mem_req, busy, if_rvalid, d_rvalid, err}), 96'(0));
                check("reset_data", 96'({if_rdata, d_rdata}), 96'(0));
                check("reset_mem", 96'({mem_we, mem_size, mem_addr, mem_wdata}), 96'(0));
            end
            pend = 0;
            done_next = 0;
            ds = 0;
        end else begin
            rv = if_rvalid || d_rvalid;
            check("rvalid_timing", 96'(rv), 96'(done_next));
            if (rv) check("rvalid_kind", 96'({if_rvalid, d_rvalid}), pend_fetch ? 96'(2) : 96'(1));
            if (if_rvalid) begin
                if (if_exp_q.size() == 0) fail_now("if_resp_unexpected");
                else begin
                    e = if_exp_q.pop_front();
                    check("if_resp", 96'({err, if_rdata}), 96'(e));
                end
                f_rv_cyc = cyc;
            end
            if (d_rvalid) begin
                if (d_exp_q.size() == 0) fail_now("d_resp_unexpected");
                else begin
                    e = d_exp_q.pop_front();
                    check("d_resp", 96'({err, d_rdata}), 96'(e));
                end
                d_rv_cyc = cyc;
            end
            if (!rv) check("idle_outputs", 96'({err, if_rdata, d_rdata}), 96'(0));
            if (done_next) pend = 0;
            check("busy", 96'(busy), 96'(pend));
            check("mem_req", 96'(mem_req), 96'(pend));
            done_next = 0;
            if (pend) begin
                check("gnt_while_busy", 96'({if_gnt, d_gnt}), 96'(0));
                if (mem_req) begin
                    if (pend_fetch)
                        check("mem_fetch", 96'({mem_we, mem_size, mem_addr}),
                              96'({1'b0, 3'b010, acc_addr}));
                    else
                        check("mem_data", 96'({mem_we, mem_size, mem_addr, mem_wdata}),
                              96'({acc_we, acc_size, acc_addr, acc_wdata}));
                    run++;
                    if (mem_ready) done_next = 1;
                    else begin
                        stall_cnt++;
                        if (stall_cnt == TIMEOUT_P) done_next = 1;
                    end
                end
            end else begin
                // data first, unless fetch already sat through MAXB data grants
                exp_d = d_req && !(if_req && ds == MAXB);
                exp_i = if_req && !exp_d;
                check("grant", 96'({if_gnt, d_gnt}), 96'({exp_i, exp_d}));
                if (exp_d) begin
                    ds = if_req ? ((ds < MAXB) ? ds + 1 : ds) : 0;
                    pend_fetch = 0;
                    acc_we = d_we; acc_size = d_size; acc_addr = d_addr; acc_wdata = d_wdata;
                    gnt_log.push_back(1'b1);
                end else if (exp_i) begin
                    ds = 0;
                    pend_fetch = 1;
                    acc_addr = if_addr;
                    gnt_log.push_back(1'b0);
                    f_gnt_cyc = cyc;
                end
                if (exp_d || exp_i) begin
                    pend = 1;
                    stall_cnt = 0;
                    run = 0;
                end
            end
        end
        rst_prev = rst;
    end

    // ---------------- driver tasks (entered at posedge+1) ----------------
    task automatic f_access(input logic [31:0] a, input bit e);
        int c;
        c = 0;
        if_addr = a;
        if_req  = 1'b1;
        if_exp_q.push_back({e, e ? 32'h0 : mem_val(a)});
        do begin
            @(negedge clk);
            c++;
        end while (!if_gnt && c < 400);
        if (!if_gnt) fail_now("if_gnt_wait");
        @(posedge clk);
        #1;
        if_req  = 1'b0;
        if_addr = $urandom;
    endtask

    task automatic d_access(input logic we, input logic [2:0] size, input logic [31:0] a,
                            input logic [31:0] wd, input bit e);
        int c;
        c = 0;
        d_we    = we;
        d_size  = size;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        d_exp_q.push_back({e, (e || we) ? 32'h0 : mem_val(a)});
        do begin
            @(negedge clk);
            c++;
        end while (!d_gnt && c < 400);
        if (!d_gnt) fail_now("d_gnt_wait");
        @(posedge clk);
        #1;
        d_req   = 1'b0;
        d_addr  = $urandom;
        d_wdata = $urandom;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((if_exp_q.size() != 0 || d_exp_q.size() != 0) && c < 1000) begin
            @(posedge clk);
            c++;
        end
        #1;
        if (c >= 1000) fail_now("drain");
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int idx;
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_size = 3'b000;
        mem_ready = 1'b0; mem_rdata = '0;
        fix_lat = 2;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        gap(1);

        // fetch only, memory answers one cycle after mem_req rises
        f_access(32'h100, 1'b0);
        drain();
        check("fetch_latency", 96'(f_rv_cyc - f_gnt_cyc), 96'(3));
        check("fetch_mem_req_cycles", 96'(run), 96'(2));
        fix_lat = 0;

        // both requesting in IDLE: data first, fetch in the data rvalid cycle
        gnt_log.delete();
        fork
            f_access(32'h104, 1'b0);
            d_access(1'b0, 3'b010, 32'h2000, 32'h0, 1'b0);
        join
        drain();
        check("both_grant_count", 96'(gnt_log.size()), 96'(2));
        if (gnt_log.size() == 2) check("both_data_first", 96'({gnt_log[0], gnt_log[1]}), 96'(2));
        check("both_fetch_slot", 96'(f_gnt_cyc), 96'(d_rv_cyc));

        // starvation guard: data held busy, fetch waits MAXB data grants
        gnt_log.delete();
        fork
            f_access(32'h300, 1'b0);
            for (int i = 0; i < 6; i++) d_access(1'b0, 3'b010, 32'h4000 + 32'(4 * i), 32'h0, 1'b0);
        join
        drain();
        idx = -1;
        for (int i = gnt_log.size() - 1; i >= 0; i--) if (!gnt_log[i]) idx = i;
        check("starve_fetch_pos", 96'(idx), 96'(MAXB));
        check("starve_grant_count", 96'(gnt_log.size()), 96'(7));

        // halfword store
        d_access(1'b1, 3'b001, 32'h2002, 32'h0000_ABCD, 1'b0);
        drain();

        // timeout: memory never answers
        stall = 1;
        f_access(32'h500, 1'b1);
        drain();
        check("timeout_mem_req_cycles", 96'(run), 96'(TIMEOUT_P));
        d_access(1'b1, 3'b010, 32'h2100, 32'h1234_5678, 1'b1);
        drain();

        // reset two cycles after grant: no response, then normal service
        f_access(32'h600, 1'b0);
        gap(1);
        rst = 1'b1;
        gap(1);
        rst = 1'b0;
        void'(if_exp_q.pop_back());
        stall = 0;
        gap(3);
        d_access(1'b0, 3'b100, 32'h7000, 32'h0, 1'b0);
        drain();

        // randomized mixed traffic
        fork
            for (int i = 0; i < 25; i++) begin
                gap($urandom_range(0, 3));
                f_access(32'h1000_0000 + 32'(4 * $urandom_range(0, 255)), 1'b0);
            end
            for (int i = 0; i < 35; i++) begin
                gap($urandom_range(0, 3));
                d_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                         32'h2000_0000 + 32'($urandom_range(0, 1023)), $urandom, 1'b0);
            end
        join
        drain();

        check("queues_empty", 96'(if_exp_q.size() + d_exp_q.size()), 96'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
